// File: rtl/uart_console_ctrl_if.sv
// Register bus between uart_console_ctrl and a single uart_fifo instance.
// The controller is the only master; dout returns one cycle after a rd.
interface uart_console_ctrl_if;
    logic       bus_wr;
    logic       bus_rd;
    logic [1:0] bus_adr;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;

    modport master (
        output bus_wr,
        output bus_rd,
        output bus_adr,
        output bus_din,
        input  bus_dout
    );

    modport slave (
        input  bus_wr,
        input  bus_rd,
        input  bus_adr,
        input  bus_din,
        output bus_dout
    );
endinterface

// File: rtl/uart_console_ctrl.sv
// Polls a uart_fifo, drains RX into a byte stream and sends a buffered line.
// UART_CONSOLE_LF_FILTER_EN: when defined, received 0x0A bytes raise no rx_valid.
module uart_console_ctrl #(
    parameter int LINE_DEPTH = 32,
    parameter int AW         = 5,
    parameter int POLL_GAP   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic [AW:0]   line_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rx_valid,
    output logic [7:0]    rx_byte,
    uart_console_ctrl_if.master bus
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        POLL,
        STAT,
        RXRD,
        RXCAP,
        TXWR,
        GAP
    } state_t;

    localparam state_t AFTER = (POLL_GAP == 0) ? POLL : GAP;

    state_t        state_q;
    state_t        state_d;
    logic [GW-1:0] gap_q;
    logic [AW:0]   len_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   len_clamped;
    logic [7:0]    buf_mem [LINE_DEPTH];
    logic          start_ok;
    logic          last_wr;
    logic          rx_keep;

    logic          bus_wr_q;
    logic          bus_rd_q;
    logic [1:0]    bus_adr_q;
    logic [7:0]    bus_din_q;

    assign bus.bus_wr  = bus_wr_q;
    assign bus.bus_rd  = bus_rd_q;
    assign bus.bus_adr = bus_adr_q;
    assign bus.bus_din = bus_din_q;

    assign start_ok = start && !busy && (state_q != TXWR);

    assign len_clamped =
        (line_len > (AW+1)'(LINE_DEPTH)) ?
        (AW+1)'(LINE_DEPTH) : line_len;

    assign last_wr = (state_q == TXWR) &&
                     ((idx_q + (AW+1)'(1)) == len_q);

`ifdef UART_CONSOLE_LF_FILTER_EN
    assign rx_keep = (bus.bus_dout != 8'h0A);
`else
    assign rx_keep = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            POLL: state_d = STAT;
            STAT: begin
                if (bus.bus_dout[0]) begin
                    state_d = RXRD;
                end else if (busy && !bus.bus_dout[1]) begin
                    state_d = TXWR;
                end else begin
                    state_d = AFTER;
                end
            end
            RXRD:  state_d = RXCAP;
            RXCAP: state_d = AFTER;
            TXWR:  state_d = AFTER;
            GAP: begin
                if (gap_q == '0) begin
                    state_d = POLL;
                end
            end
            default: state_d = POLL;
        endcase
    end

    // Reset parks in GAP with an expired count so the first edge after
    // release issues the status read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAP;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != GAP && state_d == GAP) begin
                gap_q <= GW'(POLL_GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_wr_q  <= 1'b0;
            bus_rd_q  <= 1'b0;
            bus_adr_q <= 2'b00;
            bus_din_q <= 8'h00;
        end else begin
            bus_rd_q  <= (state_d == POLL) || (state_d == RXRD);
            bus_wr_q  <= (state_d == TXWR);
            bus_adr_q <= (state_d == POLL) ? 2'b10 : 2'b00;
            bus_din_q <= (state_d == TXWR) ?
                         buf_mem[idx_q[AW-1:0]] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                len_q <= len_clamped;
                idx_q <= '0;
                if (len_clamped == '0) begin
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end else if (state_q == TXWR) begin
                idx_q <= idx_q + (AW+1)'(1);
                if (last_wr) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
        end else begin
            rx_valid <= (state_q == RXCAP) && rx_keep;
            if (state_q == RXCAP) begin
                rx_byte <= bus.bus_dout;
            end
        end
    end

    // Buffer is frozen while a line is in flight.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            buf_mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_uart_console_ctrl.sv
// Randomized scoreboard bench for uart_console_ctrl with a uart_fifo model.
// Expected TX bytes, RX bytes and done pulses are queued by stimulus.
module tb_uart_console_ctrl;

    localparam int LD = 32;
    localparam int AW = 5;
    localparam int PG = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic [AW:0]   line_len = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          rx_valid;
    logic [7:0]    rx_byte;

    uart_console_ctrl_if bus_if ();

    uart_console_ctrl #(
        .LINE_DEPTH(LD),
        .AW(AW),
        .POLL_GAP(PG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .line_len(line_len),
        .start(start),
        .busy(busy),
        .done(done),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  rxq[$];
    int          exp_done = 0;
    int          target_done = 0;
    int          done_seen = 0;
    int          wr_seen = 0;
    int          rx_flag_cnt = 0;
    int          rx_flag_done = 0;
    logic        tx_hold = 1'b0;
    logic [7:0]  line [LD];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, got);
    endtask

    function automatic bit rx_expect(input logic [7:0] b);
`ifdef UART_CONSOLE_LF_FILTER_EN
        return b != 8'h0A;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // uart_fifo model: registered dout, status = {tx_busy, rx_avail}
    always @(posedge clk) begin
        if (!rst_n) begin
            bus_if.bus_dout <= 8'h00;
        end else if (bus_if.bus_rd) begin
            if (bus_if.bus_adr == 2'b10) begin
                bus_if.bus_dout <= {6'b0, tx_hold, rxq.size() != 0};
                if (rxq.size() != 0) rx_flag_cnt++;
            end else if (rxq.size() != 0) begin
                bus_if.bus_dout <= rxq.pop_front();
            end else begin
                bus_if.bus_dout <= 8'hEE;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_flag_done = rx_flag_cnt;
        end else begin
            if (bus_if.bus_wr || (bus_if.bus_rd && bus_if.bus_adr != 2'b10)) begin
                if (rx_flag_cnt > rx_flag_done) begin
                    chk("rx_priority", {bus_if.bus_rd, bus_if.bus_wr,
                        bus_if.bus_adr}, {1'b1, 1'b0, 2'b00});
                    rx_flag_done = rx_flag_cnt;
                end
            end
            if (bus_if.bus_wr) begin
                wr_seen++;
                chk("rd_wr_excl", bus_if.bus_rd, 0);
                chk("tx_adr", bus_if.bus_adr, 0);
                chk("tx_busy", busy, 1);
                if (exp_tx.size() == 0) fail_now("unexpected_wr", bus_if.bus_din);
                else chk("tx_din", bus_if.bus_din, exp_tx.pop_front());
            end
            if (!bus_if.bus_wr && !bus_if.bus_rd) begin
                chk("idle_bus", {bus_if.bus_adr, bus_if.bus_din}, 0);
            end
            if (rx_valid) begin
                if (exp_rx.size() == 0) fail_now("unexpected_rx", rx_byte);
                else chk("rx_byte", rx_byte, exp_rx.pop_front());
            end
            if (done) begin
                done_seen++;
                if (exp_done == 0) begin
                    fail_now("unexpected_done", 1);
                end else begin
                    exp_done--;
                    chk("done_tx_empty", exp_tx.size(), 0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < LD; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = line[i];
            tick(1);
        end
        load_we = 1'b0;
    endtask

    task automatic rand_line();
        for (int i = 0; i < LD; i++) line[i] = 8'($urandom);
    endtask

    task automatic send(input int n);
        int eff;
        eff = (n > LD) ? LD : n;
        for (int i = 0; i < eff; i++) exp_tx.push_back(line[i]);
        exp_done++;
        target_done++;
        line_len = (AW+1)'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (eff == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
        end else begin
            chk("start_busy", busy, 1);
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (done_seen >= target_done) break;
            tick(1);
        end
        if (i == 3000) fail_now("done_timeout", done_seen);
    endtask

    task automatic wait_wr(input int n);
        int i;
        for (i = 0; i < 1000; i++) begin
            if (wr_seen >= n) break;
            tick(1);
        end
        if (i == 1000) fail_now("wr_timeout", wr_seen);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        if (rx_expect(b)) exp_rx.push_back(b);
    endtask

    task automatic wait_rx_drain();
        int i;
        for (i = 0; i < 500; i++) begin
            if (exp_rx.size() == 0 && rxq.size() == 0) break;
            tick(1);
        end
        tick(3);
        chk("rx_drained", exp_rx.size() + rxq.size(), 0);
    endtask

    initial begin
        longint rel;
        longint tpoll [5];
        int     w0;
        int     n;
        bit     found;

        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxb", rx_byte, 0);
        chk("rst_bus", {bus_if.bus_wr, bus_if.bus_rd, bus_if.bus_adr,
                        bus_if.bus_din}, 0);
        rst_n = 1'b1;
        rel = cyc;

        // poll cadence with idle status
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int j = 0; j < 50 && !found; j++) begin
                @(negedge clk);
                if (bus_if.bus_rd && bus_if.bus_adr == 2'b10) begin
                    found = 1'b1;
                    tpoll[k] = cyc;
                end
            end
            if (!found) fail_now("poll_timeout", k);
        end
        chk("first_poll", 32'(tpoll[0] - rel), 1);
        for (int k = 1; k < 5; k++)
            chk("poll_period", 32'(tpoll[k] - tpoll[k-1]), PG + 2);
        tick(1);
        chk("idle_no_wr", wr_seen, 0);

        // "w w\r"
        rand_line();
        line[0] = 8'h77;
        line[1] = 8'h20;
        line[2] = 8'h77;
        line[3] = 8'h0D;
        load_all();
        w0 = wr_seen;
        send(4);
        wait_done();
        chk("ww_count", wr_seen - w0, 4);
        chk("ww_busy_end", busy, 0);

        // tx_busy hold; ignored start and loads while busy
        rand_line();
        load_all();
        w0 = wr_seen;
        send(20);
        wait_wr(w0 + 3);
        tx_hold = 1'b1;
        tick(10);
        w0 = wr_seen;
        line_len = 6'd3;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i + 4);
            load_data = 8'($urandom);
            tick(1);
            start = 1'b0;
        end
        load_we = 1'b0;
        tick(40);
        chk("hold_no_wr", wr_seen, w0);
        tx_hold = 1'b0;
        wait_done();

        // RX during send
        rand_line();
        load_all();
        w0 = wr_seen;
        send(16);
        wait_wr(w0 + 4);
        push_rx(8'h31);
        wait_done();
        wait_rx_drain();

        // RX sequence with line feed
        push_rx(8'h30);
        push_rx(8'h0A);
        push_rx(8'h31);
        wait_rx_drain();

        // randomized sends, including clamp boundaries
        for (int it = 0; it < 8; it++) begin
            rand_line();
            load_all();
            if (it == 0) n = LD;
            else if (it == 1) n = 40;
            else if (it == 2) n = 1;
            else n = $urandom_range(0, 40);
            w0 = wr_seen;
            send(n);
            if ($urandom_range(0, 1) == 1) begin
                for (int r = 0; r < 3; r++)
                    push_rx(($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom));
            end
            wait_done();
            chk("rand_count", wr_seen - w0, (n > LD) ? LD : n);
            wait_rx_drain();
        end

        // zero-length line
        w0 = wr_seen;
        send(0);
        tick(1);
        chk("len0_busy_after", busy, 0);
        wait_done();
        tick(30);
        chk("len0_no_wr", wr_seen, w0);

        // reset mid-send
        rand_line();
        load_all();
        w0 = wr_seen;
        send(20);
        wait_wr(w0 + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr", bus_if.bus_wr, 0);
        chk("mid_rst_done", done, 0);
        exp_tx.delete();
        exp_done = 0;
        target_done = done_seen;
        rxq.delete();
        exp_rx.delete();
        tick(3);
        rst_n = 1'b1;
        w0 = wr_seen;
        tick(200);
        chk("post_rst_wr", wr_seen, w0);
        chk("post_rst_done", done_seen, target_done);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_console_ctrl.md
Name: uart_console_ctrl

Overview:
- Host-side sequencer for the uart_fifo register interface (wr/rd/adr/din/dout).
- Replaces hand-written bench polling loops: continuously polls the status register, drains received characters into a byte stream, and transmits a preloaded command line (e.g. a Forth line ending in 0x0D) into the J1 console.
- Sits between a test/debug harness and one uart_fifo instance. It is the sole bus master on that uart_fifo.

Parameters:
- LINE_DEPTH, 32, number of bytes in the internal line buffer (power of 2).
- AW, 5, buffer address width; log2(LINE_DEPTH).
- POLL_GAP, 8, idle cycles between bus transactions. 0 means back-to-back.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_we  in  1  write one byte into line buffer
- load_addr  in  AW  line buffer write address
- load_data  in  8  line buffer write data
- line_len  in  AW+1  bytes to send (0..LINE_DEPTH), sampled on accepted start
- start  in  1  begin transmitting buffer[0..line_len-1]
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after last byte written
- rx_valid  out  1  one-cycle strobe: rx_byte holds a received character
- rx_byte  out  8  received character
- bus_wr  out  1  uart_fifo wr
- bus_rd  out  1  uart_fifo rd
- bus_adr  out  2  uart_fifo adr: 2'b00 data, 2'b10 status
- bus_din  out  8  uart_fifo din
- bus_dout  in  8  uart_fifo dout. Valid on the clock edge one cycle after the rd cycle. Status bit0 = rx data available, bit1 = tx busy.

Behaviour:
Bus outputs:
- All bus outputs are registered.
- Reset values: bus_wr=0, bus_rd=0, bus_adr=0, bus_din=0, busy=0, done=0, rx_valid=0, rx_byte=0. Buffer contents are not reset.
- Between transactions, bus_rd, bus_wr, bus_adr and bus_din are all 0.

FSM states: POLL, STAT, RXRD, RXCAP, TXWR, GAP.
- POLL: bus_rd=1, bus_adr=2'b10 for exactly one cycle, then go to STAT.
- STAT: bus_rd=0. Sample bus_dout at the end of this cycle, then decide:
  - If bit0=1, go to RXRD. RX has priority over TX.
  - Else if busy=1 and bit1=0, go to TXWR.
  - Else go to GAP.
- RXRD: bus_rd=1, bus_adr=2'b00 for one cycle, then go to RXCAP.
- RXCAP: capture bus_dout into rx_byte and pulse rx_valid for one cycle, then go to GAP.
- TXWR: bus_wr=1, bus_adr=2'b00, bus_din=buf[idx] for one cycle. Then idx increments. If idx reaches len, clear busy, pulse done on the next cycle, and go to GAP.
- GAP: wait POLL_GAP cycles, then go to POLL. When POLL_GAP=0, skip GAP.

Polling:
- Polling runs continuously from the first cycle after reset release, whether or not busy is set.
- RX is always drained.

start handling:
- start is accepted only when busy=0 and the FSM is not in TXWR.
- On acceptance: latch line_len into len, set idx=0, set busy=1 in the next cycle.
- start while busy=1 is ignored.
- line_len=0: no busy, no bus writes; done pulses in the cycle after start.
- line_len > LINE_DEPTH is clamped to LINE_DEPTH.

Line buffer:
- Synchronous write on load_we.
- load_we while busy=1 is ignored, so buffer contents stay stable during transmission.
- Buffer reads are combinational or registered, but must be ready by the TXWR cycle.

Bus sharing and reset:
- Exactly one transaction is in flight at a time; bus_rd and bus_wr are never both 1.
- rx_valid and done may coincide; they are independent.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), busy clears, no done pulse is generated, and the FSM restarts at POLL after reset release.

Optional Feature:
Macro UART_CONSOLE_LF_FILTER_EN controls line-feed filtering.
- Defined: received bytes equal to 0x0A are read (RX is still drained) but produce no rx_valid.
- Undefined: every received byte produces rx_valid.

Test Plan:
1. Reset, with uart_fifo model status=0x00 → after rst_n rises, a POLL read (rd=1, adr=2) occurs every POLL_GAP+2 cycles; no wr ever asserts; rx_valid stays 0.
2. Load "w w\r" (0x77,0x20,0x77,0x0D), line_len=4, pulse start, status tx_busy=0 → four bus_wr pulses with din 0x77,0x20,0x77,0x0D in order; busy high throughout; done pulses exactly once after the fourth write.
3. Status bit1=1 held for 50 cycles during a send → no bus_wr while held; transmission resumes and completes once bit1=0.
4. Status bit0=1 with data 0x31 while sending → the 0x31 read occurs before the next TX write; rx_valid pulses once with rx_byte=0x31; TX ordering is unaffected.
5. RX sequence 0x30,0x0A,0x31 → with UART_CONSOLE_LF_FILTER_EN, rx_valid fires for 0x30 and 0x31 only; without it, all three fire.
6. line_len=0 start → done one cycle later, busy never 1. A separate case: assert rst_n=0 mid-send → busy, bus_wr and done go low immediately, and there is no done pulse afterwards.
